// File: rtl/jtcps_keyrx_pkg.sv
// Shared types and constant functions for the key receiver: FSM states and the
// raw-to-cfg bit permutation (word order and per-bit source index).
package jtcps_keyrx_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;

  // Word index placed in cfg slot s (slot 0 is most significant); nw = NB/2.
  function automatic int word_at(input int s, input int nw);
    int r;
    if (s <= nw - 5)       r = s;
    else if (s == nw - 4)  r = nw - 3;
    else if (s == nw - 3)  r = nw - 4;
    else if (s == nw - 2)  r = nw - 1;
    else                   r = nw - 2;
    if (r < 0 || r >= nw) r = s;
    return r;
  endfunction

  // raw bit index feeding bit k (15 = MSB) of cfg word w.
  function automatic int src_bit(input int w, input int k, input int nw);
    int p;
    p = (w + nw - 1) % nw;
    if (k >= 10)     return 16 * w + 10 + (15 - k);
    else if (k >= 2) return 16 * w + (9 - k);
    else if (k == 1) return 16 * p + 8;
    else             return 16 * p + 9;
  endfunction

endpackage

// File: rtl/jtcps_keyrx_perm.sv
// Pure combinational permutation of the received raw bytes into cfg words.
module jtcps_keyrx_perm
  import jtcps_keyrx_pkg::*;
#(
  parameter int unsigned NB = 20
) (
  input  logic [8*NB-1:0] raw,
  output logic [8*NB-1:0] cfg
);

  localparam int NW   = NB / 2;
  localparam int CfgW = 8 * NB;

  for (genvar s = 0; s < NW; s++) begin : g_slot
    localparam int Wd = word_at(s, NW);
    for (genvar k = 0; k < 16; k++) begin : g_bit
      assign cfg[CfgW - 16 - 16 * s + k] = raw[src_bit(Wd, k, NW)];
    end
  end

endmodule

// File: rtl/jtcps_keyrx.sv
// Key stream receiver: edge-qualified byte capture, payload sum, optional checksum.
// Optional JTCPS_KEYRX_FALLBACK_EN forces cfg[9:0] high while idle or in error.
module jtcps_keyrx
  import jtcps_keyrx_pkg::*;
#(
  parameter int unsigned NB   = 20,
  parameter int unsigned SUMW = 12,
  parameter int unsigned CHK  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic [7:0]      din,
  input  logic            din_we,
  output logic            busy,
  output logic            key_ok,
  output logic            key_err,
  output logic [SUMW-1:0] sum,
  output logic [15:0]     addr_rng,
  output logic [63:0]     key
);

  localparam int RawW = 8 * NB;
  localparam int ExtW = (RawW < 64) ? 64 : RawW;
  localparam int CntW = $clog2(NB + 1);

  state_e            state_q;
  logic [RawW-1:0]   raw_q;
  logic [SUMW-1:0]   sum_q;
  logic [CntW-1:0]   cnt_q;
  logic              we_q, busy_q, key_ok_q, key_err_q;
  logic              we_rise;
  logic [7:0]        chk_lo;
  logic [RawW-1:0]   cfg, cfg_out;
  logic [ExtW-1:0]   cfg_ext;
  logic              unused_cfg;

  assign we_rise = din_we & ~we_q;
  assign chk_lo  = 8'(sum_q) + din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      raw_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      key_ok_q  <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      we_q <= din_we;
      if (clr) begin
        state_q   <= StIdle;
        raw_q     <= '0;
        sum_q     <= '0;
        cnt_q     <= '0;
        busy_q    <= 1'b0;
        key_ok_q  <= 1'b0;
        key_err_q <= 1'b0;
      end else if (we_rise) begin
        unique case (state_q)
          StIdle, StLoad: begin
            raw_q <= {din, raw_q[RawW-1:8]};
            sum_q <= sum_q + SUMW'(din);
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(NB - 1)) begin
              if (CHK == 1) begin
                state_q <= StCheck;
                busy_q  <= 1'b1;
              end else begin
                state_q  <= StDone;
                busy_q   <= 1'b0;
                key_ok_q <= 1'b1;
              end
            end else begin
              state_q <= StLoad;
              busy_q  <= 1'b1;
            end
          end
          StCheck: begin
            state_q   <= StDone;
            busy_q    <= 1'b0;
            key_ok_q  <= (chk_lo == 8'h00);
            key_err_q <= (chk_lo != 8'h00);
          end
          StDone: begin
            state_q <= StDone;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  jtcps_keyrx_perm #(
    .NB (NB)
  ) u_perm (
    .raw (raw_q),
    .cfg (cfg)
  );

`ifdef JTCPS_KEYRX_FALLBACK_EN
  assign cfg_out = cfg | {{(RawW - 10){1'b0}}, {10{key_err_q | (state_q == StIdle)}}};
`else
  assign cfg_out = cfg;
`endif

  assign cfg_ext    = ExtW'(cfg_out);
  assign unused_cfg = ^cfg_ext;

  assign busy     = busy_q;
  assign key_ok   = key_ok_q;
  assign key_err  = key_err_q;
  assign sum      = sum_q;
  assign addr_rng = cfg_out[RawW-1 -: 16];
  assign key      = cfg_ext[63:0];

endmodule

// File: tb/tb_jtcps_keyrx.sv
// Directed self-checking bench: dut0 built with CHK=0, dut1 with CHK=1, shared stimulus.
module tb_jtcps_keyrx;
  import jtcps_keyrx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clr, din_we;
  logic [7:0]  din;
  logic        busy0, ok0, err0, busy1, ok1, err1;
  logic [11:0] sum0, sum1;
  logic [15:0] ar0, ar1;
  logic [63:0] key0, key1;
  logic [159:0] raw_m;
  logic [159:0] cfg_m;
  logic [63:0]  exp_key;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtcps_keyrx #(.NB(20), .SUMW(12), .CHK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .din_we(din_we),
    .busy(busy0), .key_ok(ok0), .key_err(err0), .sum(sum0), .addr_rng(ar0), .key(key0)
  );

  jtcps_keyrx #(.NB(20), .SUMW(12), .CHK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .din_we(din_we),
    .busy(busy1), .key_ok(ok1), .key_err(err1), .sum(sum1), .addr_rng(ar1), .key(key1)
  );

  // Independent software model of the cfg permutation for NB=20.
  function automatic logic [159:0] model_cfg(input logic [159:0] r);
    int ord [10] = '{0, 1, 2, 3, 4, 5, 7, 6, 9, 8};
    logic [159:0] c;
    logic [15:0] x;
    int w, p;
    c = '0;
    for (int s = 0; s < 10; s++) begin
      w = ord[s];
      p = (w + 9) % 10;
      for (int j = 0; j < 6; j++) x[15-j] = r[16*w+10+j];
      for (int j = 0; j < 8; j++) x[9-j]  = r[16*w+j];
      x[1] = r[16*p+8];
      x[0] = r[16*p+9];
      c[159-16*s -: 16] = x;
    end
    return c;
  endfunction

  task automatic send(input logic [7:0] b, input bit pay);
    @(negedge clk);
    din    = b;
    din_we = 1'b1;
    @(negedge clk);
    din_we = 1'b0;
    if (pay) raw_m = {b, raw_m[159:8]};
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    raw_m = '0;
  endtask

  task automatic test_reset();
    #3;
    exp_key = '0;
`ifdef JTCPS_KEYRX_FALLBACK_EN
    exp_key = 64'h3FF;
`endif
    checks++;
    if ({busy1, ok1, err1} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {busy1, ok1, err1});
    end
    checks++;
    if (sum1 !== 12'h000 || dut1.cnt_q !== 5'd0) begin
      errors++; $display("FAIL reset_sum got %h/%0d want 000/0", sum1, dut1.cnt_q);
    end
    checks++;
    if (ar1 !== 16'h0000 || key1 !== exp_key) begin
      errors++; $display("FAIL reset_cfg got %h/%h want 0000/%h", ar1, key1, exp_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_held_level();
    @(negedge clk);
    din    = 8'hAA;
    din_we = 1'b1;
    repeat (5) @(negedge clk);
    din_we = 1'b0;
    checks++;
    if (dut1.cnt_q !== 5'd1 || busy1 !== 1'b1) begin
      errors++; $display("FAIL held_we cnt=%0d busy=%b want 1/1", dut1.cnt_q, busy1);
    end
    checks++;
    if (sum1 !== 12'h0AA) begin
      errors++; $display("FAIL held_sum got %h want 0aa", sum1);
    end
    do_clr();
  endtask

  task automatic test_chk0_stream();
    for (int i = 1; i <= 19; i++) send(8'(i), 1'b1);
    checks++;
    if (ok0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL early_ok ok=%b busy=%b want 0/1", ok0, busy0);
    end
    send(8'h14, 1'b1);
    cfg_m = model_cfg(raw_m);
    checks++;
    if (ok0 !== 1'b1 || err0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL chk0_flags ok=%b err=%b busy=%b want 1/0/0", ok0, err0, busy0);
    end
    checks++;
    if (sum0 !== 12'h0D2) begin
      errors++; $display("FAIL chk0_sum got %h want 0d2", sum0);
    end
    checks++;
    if (ar0 !== 16'h0200 || ar0 !== cfg_m[159:144]) begin
      errors++; $display("FAIL chk0_addr got %h want 0200 (model %h)", ar0, cfg_m[159:144]);
    end
    checks++;
    if (key0 !== cfg_m[63:0]) begin
      errors++; $display("FAIL chk0_key got %h want %h", key0, cfg_m[63:0]);
    end
    checks++;
    if (busy1 !== 1'b1 || ok1 !== 1'b0) begin
      errors++; $display("FAIL chk1_wait busy=%b ok=%b want 1/0", busy1, ok1);
    end
    send(8'h2E, 1'b0);
    checks++;
    if (ok1 !== 1'b1 || err1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL chk1_pass ok=%b err=%b busy=%b want 1/0/0", ok1, err1, busy1);
    end
    send(8'h99, 1'b0);
    checks++;
    if (sum1 !== 12'h0D2 || ok1 !== 1'b1 || sum0 !== 12'h0D2) begin
      errors++; $display("FAIL done_ignore sum=%h/%h ok=%b want 0d2/0d2/1", sum1, sum0, ok1);
    end
    do_clr();
  endtask

  task automatic send_7ac_payload();
    for (int i = 0; i < 19; i++) send(8'h60, 1'b1);
    send(8'h8C, 1'b1);
  endtask

  task automatic test_checksum();
    send_7ac_payload();
    checks++;
    if (sum1 !== 12'h7AC) begin
      errors++; $display("FAIL cs_sum got %h want 7ac", sum1);
    end
    send(8'h54, 1'b0);
    checks++;
    if (ok1 !== 1'b1 || err1 !== 1'b0) begin
      errors++; $display("FAIL cs_good ok=%b err=%b want 1/0", ok1, err1);
    end
    do_clr();
    checks++;
    if (ok1 !== 1'b0 || sum1 !== 12'h000) begin
      errors++; $display("FAIL cs_clr ok=%b sum=%h want 0/000", ok1, sum1);
    end
    send_7ac_payload();
    send(8'h55, 1'b0);
    checks++;
    if (ok1 !== 1'b0 || err1 !== 1'b1) begin
      errors++; $display("FAIL cs_bad ok=%b err=%b want 0/1", ok1, err1);
    end
    cfg_m   = model_cfg(raw_m);
    exp_key = cfg_m[63:0];
`ifdef JTCPS_KEYRX_FALLBACK_EN
    exp_key[9:0] = 10'h3FF;
`endif
    checks++;
    if (key1 !== exp_key || ar1 !== cfg_m[159:144]) begin
      errors++; $display("FAIL err_key got %h/%h want %h/%h", key1, ar1, exp_key, cfg_m[159:144]);
    end
    do_clr();
  endtask

  task automatic test_clr_collide();
    for (int i = 0; i < 7; i++) send(8'h11, 1'b1);
    @(negedge clk);
    clr    = 1'b1;
    din    = 8'h77;
    din_we = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    din_we = 1'b0;
    raw_m  = '0;
    checks++;
    if (dut1.state_q !== StIdle || sum1 !== 12'h000 || busy1 !== 1'b0) begin
      errors++; $display("FAIL clr_edge st=%0d sum=%h busy=%b want 0/000/0",
                         dut1.state_q, sum1, busy1);
    end
    send(8'h33, 1'b1);
    checks++;
    if (sum1 !== 12'h033 || dut1.cnt_q !== 5'd1 || busy1 !== 1'b1) begin
      errors++; $display("FAIL clr_next sum=%h cnt=%0d busy=%b want 033/1/1",
                         sum1, dut1.cnt_q, busy1);
    end
    do_clr();
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 10; i++) send(8'(i), 1'b1);
    @(negedge clk);
    din    = 8'h0B;
    din_we = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, ok1, err1} !== 3'b000 || sum1 !== 12'h000 || dut1.cnt_q !== 5'd0) begin
      errors++; $display("FAIL async_rst flags=%b sum=%h cnt=%0d want 000/000/0",
                         {busy1, ok1, err1}, sum1, dut1.cnt_q);
    end
    @(negedge clk);
    din_we = 1'b0;
    rst_n  = 1'b1;
    raw_m  = '0;
    for (int i = 1; i <= 20; i++) send(8'(i), 1'b1);
    send(8'h2E, 1'b0);
    checks++;
    if (ok1 !== 1'b1 || err1 !== 1'b0 || sum1 !== 12'h0D2) begin
      errors++; $display("FAIL resend ok=%b err=%b sum=%h want 1/0/0d2", ok1, err1, sum1);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    din    = 8'h00;
    din_we = 1'b0;
    raw_m  = '0;
    test_reset();
    test_held_level();
    test_chk0_stream();
    test_checksum();
    test_clr_collide();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
